bp_cfg_stream_loader: RTL and testbench

// - Runtime successor to the static processor-config table: streams the fields of one

---
 rtl/bp_cfg_stream_loader_if.sv | 16 +
 rtl/bp_cfg_stream_loader.sv | 133 +++++++++++++
 tb/tb_bp_cfg_stream_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_cfg_stream_loader_if.sv
// Config write channel: one (dst, addr, data) write per valid/ready handshake.
// The loader drives the master side; the tiles' config registers sit on the slave side.
interface bp_cfg_stream_loader_if #(
  parameter int dst_width_p  = 2,
  parameter int addr_width_p = 6,
  parameter int data_width_p = 40
);
  logic                    v;
  logic [dst_width_p-1:0]  dst;
  logic [addr_width_p-1:0] addr;
  logic [data_width_p-1:0] data;
  logic                    ready;

  modport master (output v, output dst, output addr, output data, input ready);
  modport slave  (input v, input dst, input addr, input data, output ready);
endinterface

// File: rtl/bp_cfg_stream_loader.sv
// Streams every field of one selected processor config from the config ROM to
// each destination tile, field-major and destination-minor. Slot 0 and slots at
// or beyond num_cfgs_p are rejected with a one-cycle err_o and nothing is sent.
module bp_cfg_stream_loader #(
  parameter int num_cfgs_p    = 128,
  parameter int num_fields_p  = 48,
  parameter int field_width_p = 40,
  parameter int num_dst_p     = 4,
  localparam int lg_cfgs_lp        = (num_cfgs_p > 1) ? $clog2(num_cfgs_p) : 1,
  localparam int lg_fields_lp      = (num_fields_p > 1) ? $clog2(num_fields_p) : 1,
  localparam int lg_dst_lp         = (num_dst_p > 1) ? $clog2(num_dst_p) : 1,
  localparam int rom_addr_width_lp = (num_cfgs_p * num_fields_p > 1)
                                     ? $clog2(num_cfgs_p * num_fields_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_v_i,
  input  logic [lg_cfgs_lp-1:0]        cfg_sel_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         rom_v_o,
  output logic [rom_addr_width_lp-1:0] rom_addr_o,
  input  logic [field_width_p-1:0]     rom_data_i,
  bp_cfg_stream_loader_if.master       cfg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                   state_r, state_n;
  logic [lg_cfgs_lp-1:0]    sel_r;
  logic [lg_fields_lp-1:0]  field_cnt_r;
  logic [lg_dst_lp-1:0]     dst_cnt_r;
  logic [field_width_p-1:0] data_r;
  logic                     err_r;

  logic sel_ok;
  logic last_dst;
  logic last_field;
  logic send_hs;

  assign sel_ok     = (cfg_sel_i != '0) && (int'(cfg_sel_i) < num_cfgs_p);
  assign last_dst   = (dst_cnt_r == lg_dst_lp'(num_dst_p - 1));
  assign last_field = (field_cnt_r == lg_fields_lp'(num_fields_p - 1));
  assign send_hs    = (state_r == SEND) && cfg.ready;

  // State, counters, latched selection and the field data register.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      field_cnt_r <= '0;
      dst_cnt_r   <= '0;
      // NOTE: data_r is a single register, not a memory; resetting it keeps cfg data at 0.
      data_r      <= '0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_n;
      err_r   <= (state_r == IDLE) && start_v_i && !sel_ok;

      if (state_r == IDLE) begin
        field_cnt_r <= '0;
        dst_cnt_r   <= '0;
        if (start_v_i) sel_r <= cfg_sel_i;
      end

      if (state_r == WAIT) begin
        data_r    <= rom_data_i;
        dst_cnt_r <= '0;
      end

      if (send_hs) begin
        if (!last_dst) begin
          dst_cnt_r <= dst_cnt_r + 1'b1;
        end else begin
          dst_cnt_r   <= '0;
          field_cnt_r <= last_field ? '0 : field_cnt_r + 1'b1;
        end
      end
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n = state_r;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    rom_v_o = 1'b0;
    cfg.v   = 1'b0;
    unique case (state_r)
      IDLE: if (start_v_i && sel_ok) state_n = READ;
      READ: begin
        busy_o  = 1'b1;
        rom_v_o = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        busy_o  = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        busy_o = 1'b1;
        cfg.v  = 1'b1;
        if (cfg.ready && last_dst) state_n = last_field ? DONE : READ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Full-width ROM address so sel*num_fields_p never truncates.
  always_comb begin
    rom_addr_o = rom_addr_width_lp'(sel_r) * rom_addr_width_lp'(num_fields_p)
               + rom_addr_width_lp'(field_cnt_r);
  end

  assign err_o    = err_r;
  assign cfg.dst  = dst_cnt_r;
  assign cfg.addr = field_cnt_r;
  assign cfg.data = data_r;

endmodule

// File: tb/tb_bp_cfg_stream_loader.sv
// Bench for bp_cfg_stream_loader: a 100-slot, 48-field, 4-tile instance and a
// 1-field, 1-tile instance, each fed by a random-filled synchronous ROM.
module tb_bp_cfg_stream_loader;

  typedef struct packed {
    logic [1:0]  dst;
    logic [5:0]  addr;
    logic [39:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 100 configs, 48 fields, 4 destinations
  logic        a_start = 1'b0;
  logic [6:0]  a_sel = '0;
  logic        a_busy, a_done, a_err, a_rom_v;
  logic [12:0] a_rom_addr;
  logic [39:0] a_rom_data = '0;
  logic        a_ready = 1'b1;
  logic [39:0] rom_a [0:8191];

  bp_cfg_stream_loader_if #(.dst_width_p(2), .addr_width_p(6), .data_width_p(40)) a_if ();
  assign a_if.ready = a_ready;

  bp_cfg_stream_loader #(.num_cfgs_p(100), .num_fields_p(48), .field_width_p(40), .num_dst_p(4)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .start_v_i(a_start), .cfg_sel_i(a_sel),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .rom_v_o(a_rom_v),
    .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data), .cfg(a_if.master));

  // Instance B: 4 configs, 1 field, 1 destination
  logic        b_start = 1'b0;
  logic [1:0]  b_sel = '0;
  logic        b_busy, b_done, b_err, b_rom_v;
  logic [1:0]  b_rom_addr;
  logic [39:0] b_rom_data = '0;
  logic        b_ready = 1'b1;
  logic [39:0] rom_b [0:3];

  bp_cfg_stream_loader_if #(.dst_width_p(1), .addr_width_p(1), .data_width_p(40)) b_if ();
  assign b_if.ready = b_ready;

  bp_cfg_stream_loader #(.num_cfgs_p(4), .num_fields_p(1), .field_width_p(40), .num_dst_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .start_v_i(b_start), .cfg_sel_i(b_sel),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .rom_v_o(b_rom_v),
    .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data), .cfg(b_if.master));

  // Synchronous ROMs: data valid one cycle after the read enable
  always @(posedge clk) begin
    if (a_rom_v) a_rom_data <= rom_a[a_rom_addr];
    if (b_rom_v) b_rom_data <= rom_b[b_rom_addr];
  end

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling edge
  int  cyc = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  a_done_cnt = 0, a_err_cnt = 0, a_romv_cnt = 0, a_cfgv_cnt = 0, a_stab_err = 0;
  int  a_start_cyc = 0, a_done_cyc = 0, a_err_cyc = 0;
  bit  a_prev_stall = 1'b0;
  wr_t a_prev;
  int  b_hs_cnt = 0, b_hs_cyc = 0, b_done_cnt = 0, b_done_cyc = 0;
  wr_t b_obs;

  always @(negedge clk) begin
    cyc++;
    if (a_start) a_start_cyc = cyc;
    if (a_if.v && a_if.ready) obs_q.push_back({a_if.dst, a_if.addr, a_if.data});
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (a_err) begin a_err_cnt++; a_err_cyc = cyc; end
    if (a_rom_v) a_romv_cnt++;
    if (a_if.v) a_cfgv_cnt++;
    if (reset_i) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall && !(a_if.v && ({a_if.dst, a_if.addr, a_if.data} == a_prev))) a_stab_err++;
      a_prev_stall = a_if.v && !a_if.ready;
      a_prev = {a_if.dst, a_if.addr, a_if.data};
    end
    if (b_if.v && b_if.ready) begin
      b_hs_cnt++;
      b_hs_cyc = cyc;
      b_obs = {1'b0, b_if.dst, 5'd0, b_if.addr, b_if.data};
    end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
  end

  // Reference: every field of the selected slot, each sent to all four tiles in order
  task automatic build_model(input int sel);
    exp_q.delete();
    for (int f = 0; f < 48; f++) begin
      for (int d = 0; d < 4; d++) begin
        wr_t w;
        w.dst  = 2'(d);
        w.addr = 6'(f);
        w.data = rom_a[sel * 48 + f];
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic int first_bad();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs_q.size()) return i;
      if (obs_q[i] !== exp_q[i]) return i;
    end
    if (obs_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  // All stimulus helpers start and end just after a rising edge
  task automatic pulse_start_a(input int sel);
    a_start = 1'b1;
    a_sel   = 7'(sel);
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int d0, input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (a_done_cnt > d0) begin ok = 1'b1; break; end
      if (rand_ready) a_ready = ($urandom_range(0, 99) < 30);
    end
    a_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_busy, a_done, a_err, a_rom_v, a_if.v} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 00000", {a_busy, a_done, a_err, a_rom_v, a_if.v});
    end
    checks++;
    if ({a_if.dst, a_if.addr, a_if.data, a_rom_addr} !== '0) begin
      errors++; $display("FAIL reset_data got dst=%0d addr=%0d data=%h rom_addr=%0d exp all 0",
                         a_if.dst, a_if.addr, a_if.data, a_rom_addr);
    end
    checks++;
    if ({b_busy, b_done, b_err, b_rom_v, b_if.v} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes_b got %b exp 00000", {b_busy, b_done, b_err, b_rom_v, b_if.v});
    end
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_done_cnt !== 0 || a_err_cnt !== 0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b done_cnt=%0d err_cnt=%0d exp 0/0/0",
                         a_busy, a_done_cnt, a_err_cnt);
    end
  endtask

  task automatic test_full_load(input int sel);
    int d0, bad;
    bit ok;
    a_ready = 1'b1;
    obs_q.delete();
    build_model(sel);
    d0 = a_done_cnt;
    pulse_start_a(sel);
    wait_done_a(d0, 1000, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout sel=%0d got no done exp done", sel); end
    checks++;
    if (obs_q.size() !== 192) begin
      errors++; $display("FAIL full_count sel=%0d got %0d exp 192", sel, obs_q.size());
    end
    bad = first_bad();
    checks++;
    if (bad !== -1) begin
      errors++; $display("FAIL full_seq sel=%0d first bad write got index %0d exp none", sel, bad);
    end
    checks++;
    if (a_done_cyc - a_start_cyc !== 289) begin
      errors++; $display("FAIL full_latency sel=%0d got %0d exp 289", sel, a_done_cyc - a_start_cyc);
    end
    checks++;
    if (a_done_cnt - d0 !== 1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++; $display("FAIL full_done_pulse got pulses=%0d busy=%b done=%b exp 1/0/0",
                         a_done_cnt - d0, a_busy, a_done);
    end
  endtask

  task automatic test_invalid_sel(input int sel);
    int e0, r0, c0;
    e0 = a_err_cnt;
    r0 = a_romv_cnt;
    c0 = a_cfgv_cnt;
    pulse_start_a(sel);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_err_cnt - e0 !== 1) begin
      errors++; $display("FAIL err_pulse sel=%0d got %0d cycles exp 1", sel, a_err_cnt - e0);
    end
    checks++;
    if (a_err_cyc - a_start_cyc !== 1) begin
      errors++; $display("FAIL err_latency sel=%0d got %0d exp 1", sel, a_err_cyc - a_start_cyc);
    end
    checks++;
    if (a_romv_cnt !== r0 || a_cfgv_cnt !== c0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL err_quiet sel=%0d got rom_v=%0d cfg_v=%0d busy=%b exp 0/0/0",
                         sel, a_romv_cnt - r0, a_cfgv_cnt - c0, a_busy);
    end
  endtask

  task automatic test_random_ready(input int sel);
    int d0, bad;
    bit ok;
    obs_q.delete();
    build_model(sel);
    a_stab_err = 0;
    d0 = a_done_cnt;
    a_ready = 1'b0;
    pulse_start_a(sel);
    wait_done_a(d0, 5000, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
    bad = first_bad();
    checks++;
    if (bad !== -1) begin
      errors++; $display("FAIL stall_seq got first bad index %0d (size %0d) exp none", bad, obs_q.size());
    end
    checks++;
    if (a_stab_err !== 0) begin
      errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", a_stab_err);
    end
  endtask

  task automatic test_busy_start();
    int d0, bad;
    bit ok;
    obs_q.delete();
    build_model(3);
    d0 = a_done_cnt;
    pulse_start_a(3);
    repeat (20) @(posedge clk);
    #1;
    pulse_start_a(7);
    wait_done_a(d0, 1000, 1'b0, ok);
    repeat (20) @(posedge clk);
    #1;
    bad = first_bad();
    checks++;
    if (!ok || bad !== -1) begin
      errors++; $display("FAIL busy_start_seq got done=%b first bad %0d exp done=1 none", ok, bad);
    end
    checks++;
    if (a_done_cnt - d0 !== 1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_single got pulses=%0d busy=%b exp 1/0", a_done_cnt - d0, a_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    int d0, e0, bad;
    bit found, ok;
    found = 1'b0;
    a_ready = 1'b1;
    pulse_start_a(4);
    for (int i = 0; i < 200; i++) begin
      if (a_if.v && a_if.addr == 6'd10 && a_if.dst == 2'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach got no SEND f10 d2 exp reached"); end
    d0 = a_done_cnt;
    e0 = a_err_cnt;
    reset_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_if.v !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got cfg_v=%b busy=%b exp 0/0", a_if.v, a_busy);
    end
    reset_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (a_done_cnt !== d0 || a_err_cnt !== e0) begin
      errors++; $display("FAIL midreset_no_pulse got done=%0d err=%0d exp 0/0", a_done_cnt - d0, a_err_cnt - e0);
    end
    obs_q.delete();
    build_model(3);
    pulse_start_a(3);
    wait_done_a(d0, 1000, 1'b0, ok);
    bad = first_bad();
    checks++;
    if (!ok || bad !== -1) begin
      errors++; $display("FAIL midreset_restart got done=%b first bad %0d exp done=1 none", ok, bad);
    end
  endtask

  task automatic test_single_dst();
    int d0, h0;
    bit ok;
    ok = 1'b0;
    d0 = b_done_cnt;
    h0 = b_hs_cnt;
    b_start = 1'b1;
    b_sel   = 2'd1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (b_done_cnt > d0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || b_hs_cnt - h0 !== 1) begin
      errors++; $display("FAIL single_count got done=%b writes=%0d exp 1/1", ok, b_hs_cnt - h0);
    end
    checks++;
    if (b_obs.dst !== 2'd0 || b_obs.addr !== 6'd0 || b_obs.data !== rom_b[1]) begin
      errors++; $display("FAIL single_write got dst=%0d addr=%0d data=%h exp 0 0 %h",
                         b_obs.dst, b_obs.addr, b_obs.data, rom_b[1]);
    end
    checks++;
    if (b_done_cyc - b_hs_cyc !== 1) begin
      errors++; $display("FAIL single_done_timing got %0d exp 1", b_done_cyc - b_hs_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom_a[i] = {8'($urandom), 32'($urandom)};
    for (int i = 0; i < 4; i++) rom_b[i] = {8'($urandom), 32'($urandom)};
    test_reset();
    test_full_load(2);
    test_invalid_sel(0);
    test_invalid_sel(100);
    test_invalid_sel(127);
    test_random_ready(5);
    test_full_load(99);
    test_busy_start();
    test_reset_mid_load();
    test_single_dst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
